core_trace_monitor: RTL and testbench

- Synthesizable, parametrised successor to the core register-dump bench logic.
- Watches a multi-cycle core's pc/state/register outputs and detects programmable PC breakpoints at instruction-fetch boundaries.
- On each hit, pushes a trace record (cycle, pc, hit mask, one selected register snapshot) into a FIFO with a valid/ready drain port.
- Optionally halts the core on a hit or when a cycle-count timeout expires.
- Sits beside core in the top level and in the core benches.

---
 rtl/core_mon_pkg.sv | 31 +++
 rtl/trace_fifo.sv | 56 +++++
 rtl/core_trace_monitor.sv | 140 ++++++++++++++
 tb/tb_core_trace_monitor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mon_pkg.sv
// Shared types for the core trace monitor: monitor state encoding, record layout
// at the default widths, and default parameter values.
package core_mon_pkg;

  localparam int XLEN_D        = 32;
  localparam int NREG_D        = 32;
  localparam int STATE_W_D     = 2;
  localparam int FETCH_STATE_D = 0;
  localparam int NBP_D         = 4;
  localparam int DEPTH_D       = 8;
  localparam int CYC_W_D       = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  typedef struct packed {
    logic [CYC_W_D-1:0] cycle;
    logic [XLEN_D-1:0]  pc;
    logic [NBP_D-1:0]   mask;
    logic [XLEN_D-1:0]  data;
  } trace_rec_t;

  function automatic logic is_halt(input mon_state_t s);
    return (s == HALTED) || (s == TIMEOUT);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace record FIFO with a registered head-of-queue output and valid/ready drain.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         rd_valid,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [AW:0]   count, count_nx;
  logic          do_pop, do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && rd_valid;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_nx = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nx  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: storage has no reset; emptiness is tracked by count, so stale entries are never exposed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_nx;
      count    <= count_nx;
      rd_valid <= (count_nx != '0);
      // The new head is the word being written when it lands in the head slot.
      if (do_push && (wr_ptr == rd_ptr_nx)) rd_data <= push_data;
      else                                   rd_data <= mem[rd_ptr_nx];
    end
  end

endmodule

// File: rtl/core_trace_monitor.sv
// PC breakpoint monitor for a multi-cycle core: detects hits at fetch boundaries,
// queues trace records and optionally halts the core on a hit or cycle timeout.
module core_trace_monitor
  import core_mon_pkg::*;
#(
  parameter int XLEN        = XLEN_D,
  parameter int NREG        = NREG_D,
  parameter int STATE_W     = STATE_W_D,
  parameter int FETCH_STATE = FETCH_STATE_D,
  parameter int NBP         = NBP_D,
  parameter int DEPTH       = DEPTH_D,
  parameter int CYC_W       = CYC_W_D
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [XLEN-1:0]         pc,
  input  logic [STATE_W-1:0]      state,
  input  logic [XLEN-1:0]         register [NREG],
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    halt_on_hit,
  input  logic [CYC_W-1:0]        timeout,
  input  logic [$clog2(NREG)-1:0] snap_sel,
  input  logic                    bp_we,
  input  logic [$clog2(NBP)-1:0]  bp_idx,
  input  logic [XLEN-1:0]         bp_addr,
  input  logic                    bp_en,
  output logic                    halt_req,
  output logic [1:0]              mon_state,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [CYC_W-1:0]        rd_cycle,
  output logic [XLEN-1:0]         rd_pc,
  output logic [NBP-1:0]          rd_mask,
  output logic [XLEN-1:0]         rd_data,
  output logic                    overflow,
  output logic [15:0]             hit_count
);

  localparam int REC_W = CYC_W + XLEN + NBP + XLEN;

  mon_state_t         st, st_nx;
  logic               halt_nx;
  logic [CYC_W-1:0]   cycle_q;
  logic               prev_valid;
  logic [STATE_W-1:0] prev_state;
  logic [XLEN-1:0]    prev_pc;
  logic [XLEN-1:0]    bp_addr_q [NBP];
  logic [NBP-1:0]     bp_en_q;
  logic [NBP-1:0]     match;
  logic               fetch_ev, hit, tmo, fifo_full, pop;
  logic [REC_W-1:0]   rec_in, rec_out;

  // A core dwelling in fetch on one pc is a single instruction boundary.
  assign fetch_ev = (state == STATE_W'(FETCH_STATE)) &&
                    (!prev_valid || (prev_state != STATE_W'(FETCH_STATE)) || (prev_pc != pc));

  always_comb begin
    for (int i = 0; i < NBP; i++) match[i] = bp_en_q[i] && (bp_addr_q[i] == pc);
  end

  assign hit = fetch_ev && (|match) && (st == ARMED);
  assign tmo = (timeout != '0) && (cycle_q == timeout - CYC_W'(1));
  assign pop = rd_valid && rd_ready;

  // Monitor FSM: state register, next-state logic, output decode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= IDLE;
      halt_req <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of its peers.
      st       <= st_nx;
      halt_req <= halt_nx;
    end
  end

  always_comb begin
    st_nx = st;
    if (disarm)                        st_nx = IDLE;
    else if (arm)                      st_nx = ARMED;
    else if (st == ARMED) begin
      if (hit && halt_on_hit)          st_nx = HALTED;
      else if (tmo)                    st_nx = TIMEOUT;
    end
  end

  always_comb begin
    halt_nx = is_halt(st_nx);
  end

  assign mon_state = st;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_q    <= '0;
      prev_valid <= 1'b0;
      prev_state <= '0;
      prev_pc    <= '0;
      bp_en_q    <= '0;
      overflow   <= 1'b0;
      hit_count  <= '0;
      for (int i = 0; i < NBP; i++) bp_addr_q[i] <= '0;
    end else begin
      prev_valid <= 1'b1;
      prev_state <= state;
      prev_pc    <= pc;

      if (arm)                                 cycle_q <= '0;
      else if ((st == ARMED) && (cycle_q != '1)) cycle_q <= cycle_q + CYC_W'(1);

      if (arm)                                 overflow <= 1'b0;
      else if (hit && fifo_full && !pop)       overflow <= 1'b1;

      if (arm)                                 hit_count <= '0;
      else if (hit && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;

      if (bp_we && (int'(bp_idx) < NBP)) begin
        bp_addr_q[bp_idx] <= bp_addr;
        bp_en_q[bp_idx]   <= bp_en;
      end
    end
  end

  assign rec_in = {cycle_q, pc, match, register[snap_sel]};

  trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (hit),
    .push_data (rec_in),
    .pop       (rd_ready),
    .full      (fifo_full),
    .rd_valid  (rd_valid),
    .rd_data   (rec_out)
  );

  assign {rd_cycle, rd_pc, rd_mask, rd_data} = rec_out;

endmodule

// File: tb/tb_core_trace_monitor.sv
// Directed bench for core_trace_monitor with a queue-based reference model
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_core_trace_monitor;
  import core_mon_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rstn;
  logic [31:0] pc;
  logic [1:0]  cstate;
  logic [31:0] regs [32];
  logic        arm, disarm, halt_on_hit;
  logic [31:0] timeout;
  logic [4:0]  snap_sel;
  logic        bp_we;
  logic [1:0]  bp_idx;
  logic [31:0] bp_addr;
  logic        bp_en;
  logic        halt_req;
  logic [1:0]  mon_state;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_cycle, rd_pc, rd_data;
  logic [3:0]  rd_mask;
  logic        overflow;
  logic [15:0] hit_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_st;
  logic [31:0] m_cyc;
  logic [15:0] m_hits;
  bit          m_ovf, m_halt, m_pv;
  logic [1:0]  m_ps;
  logic [31:0] m_ppc;
  logic [31:0] m_bpa [4];
  bit          m_bpe [4];
  trace_rec_t  m_q [$];

  core_trace_monitor dut (
    .clk(clk), .rstn(rstn), .pc(pc), .state(cstate), .register(regs),
    .arm(arm), .disarm(disarm), .halt_on_hit(halt_on_hit), .timeout(timeout),
    .snap_sel(snap_sel), .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr),
    .bp_en(bp_en), .halt_req(halt_req), .mon_state(mon_state),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cycle(rd_cycle), .rd_pc(rd_pc),
    .rd_mask(rd_mask), .rd_data(rd_data), .overflow(overflow), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cyc = '0; m_hits = '0; m_ovf = 0; m_halt = 0;
    m_pv = 0; m_ps = '0; m_ppc = '0;
    for (int i = 0; i < 4; i++) begin m_bpa[i] = '0; m_bpe[i] = 0; end
    m_q.delete();
  endtask

  // One clock of specified behaviour, evaluated from the inputs held before the edge.
  task automatic model_step();
    logic [3:0] mask;
    bit         ev, hit, pop;
    int         nst;
    trace_rec_t r;
    if (!rstn) begin model_reset(); return; end
    ev = (cstate == 2'd0) && (!m_pv || m_ps != 2'd0 || m_ppc != pc);
    for (int i = 0; i < 4; i++) mask[i] = m_bpe[i] && (m_bpa[i] == pc);
    hit = ev && (mask != 0) && (m_st == 1);
    pop = (m_q.size() > 0) && rd_ready;
    r.cycle = m_cyc; r.pc = pc; r.mask = mask; r.data = regs[snap_sel];
    if (pop) void'(m_q.pop_front());
    if (hit) begin
      if (m_q.size() < DEPTH) m_q.push_back(r);
      else m_ovf = 1;
      if (m_hits != 16'hFFFF) m_hits++;
    end
    nst = m_st;
    if (disarm) nst = 0;
    else if (arm) nst = 1;
    else if (m_st == 1) begin
      if (hit && halt_on_hit) nst = 2;
      else if (timeout != 0 && m_cyc == timeout - 1) nst = 3;
    end
    if (arm) begin m_cyc = '0; m_hits = '0; m_ovf = 0; end
    else if (m_st == 1 && m_cyc != 32'hFFFF_FFFF) m_cyc++;
    m_st = nst;
    m_halt = (nst >= 2);
    m_pv = 1; m_ps = cstate; m_ppc = pc;
    if (bp_we) begin m_bpa[bp_idx] = bp_addr; m_bpe[bp_idx] = bp_en; end
  endtask

  task automatic compare();
    check("mon_state", 64'(mon_state), 64'(m_st));
    check("halt_req",  64'(halt_req),  64'(m_halt));
    check("overflow",  64'(overflow),  64'(m_ovf));
    check("hit_count", 64'(hit_count), 64'(m_hits));
    check("rd_valid",  64'(rd_valid),  64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("rd_cycle", 64'(rd_cycle), 64'(m_q[0].cycle));
      check("rd_pc",    64'(rd_pc),    64'(m_q[0].pc));
      check("rd_mask",  64'(rd_mask),  64'(m_q[0].mask));
      check("rd_data",  64'(rd_data),  64'(m_q[0].data));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic write_bp(input int idx, input logic [31:0] addr, input logic en);
    bp_we = 1'b1; bp_idx = 2'(idx); bp_addr = addr; bp_en = en;
    tick();
    bp_we = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1; tick(); disarm = 1'b0;
  endtask

  // One-cycle fetch at pc followed by one non-fetch cycle.
  task automatic fetch_once(input logic [31:0] a);
    cstate = 2'd0; pc = a; tick();
    cstate = 2'd1; tick();
  endtask

  initial begin
    rstn = 1'b0; pc = '0; cstate = 2'd1; arm = 0; disarm = 0; halt_on_hit = 0;
    timeout = '0; snap_sel = '0; bp_we = 0; bp_idx = '0; bp_addr = '0; bp_en = 0;
    rd_ready = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    model_reset();
    tick(); tick();
    check("reset mon_state", 64'(mon_state), 0);
    check("reset rd_valid",  64'(rd_valid),  0);
    check("reset hit_count", 64'(hit_count), 0);
    check("reset halt_req",  64'(halt_req),  0);
    rstn = 1'b1;
    tick();

    // Dwell two cycles in fetch on a breakpoint pc: one record only.
    write_bp(0, 32'd35, 1'b1);
    pulse_arm();
    cstate = 2'd0; pc = 32'd35; tick(); tick();
    cstate = 2'd1; tick();
    check("t1 rd_valid",  64'(rd_valid),  1);
    check("t1 rd_pc",     64'(rd_pc),     35);
    check("t1 rd_mask",   64'(rd_mask),   4'b0001);
    check("t1 rd_cycle",  64'(rd_cycle),  0);
    check("t1 hit_count", 64'(hit_count), 1);
    rd_ready = 1; tick(); rd_ready = 0;
    check("t1 single record", 64'(rd_valid), 0);

    // Two slots on one pc, halt on hit, negative register snapshot.
    write_bp(0, 32'h40, 1'b1);
    write_bp(2, 32'h40, 1'b1);
    halt_on_hit = 1; snap_sel = 5'd5; regs[5] = -32'sd7;
    pulse_arm();
    cstate = 2'd0; pc = 32'h40;
    check("t2 halt_req before hit", 64'(halt_req), 0);
    tick();
    check("t2 mon_state", 64'(mon_state), 2);
    check("t2 halt_req",  64'(halt_req),  1);
    check("t2 rd_mask",   64'(rd_mask),   4'b0101);
    check("t2 rd_data",   64'(rd_data),   32'hFFFF_FFF9);
    cstate = 2'd1;
    pulse_disarm();
    rd_ready = 1; tick(); rd_ready = 0;

    // Timeout after 100 armed cycles without hits.
    halt_on_hit = 0; timeout = 32'd100;
    pulse_arm();
    for (int i = 0; i < 99; i++) tick();
    check("t3 still armed", 64'(mon_state), 1);
    tick();
    check("t3 mon_state", 64'(mon_state), 3);
    check("t3 halt_req",  64'(halt_req),  1);
    pulse_disarm();
    check("t3 idle",          64'(mon_state), 0);
    check("t3 halt released", 64'(halt_req),  0);
    timeout = '0;

    // Ten hits into an undrained 8-deep FIFO.
    write_bp(1, 32'h80, 1'b1);
    pulse_arm();
    for (int i = 0; i < 10; i++) fetch_once(32'h80);
    check("t4 overflow",  64'(overflow),  1);
    check("t4 hit_count", 64'(hit_count), 10);
    check("t4 head pc",   64'(rd_pc),     32'h80);
    cstate = 2'd0; pc = 32'h80; rd_ready = 1; tick();
    cstate = 2'd1; rd_ready = 0; tick();
    check("t4 full push+pop hit_count", 64'(hit_count), 11);
    rd_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    rd_ready = 0;
    check("t4 drained", 64'(rd_valid), 0);

    // Rewriting slot1 in the event cycle uses the old compare value.
    pulse_arm();
    cstate = 2'd0; pc = 32'h90;
    bp_we = 1; bp_idx = 2'd1; bp_addr = 32'h90; bp_en = 1;
    tick();
    bp_we = 0; cstate = 2'd1;
    check("t5 no hit on write cycle", 64'(hit_count), 0);
    check("t5 no record",             64'(rd_valid),  0);
    tick();
    fetch_once(32'h90);
    check("t5 hit_count", 64'(hit_count), 1);
    check("t5 rd_mask",   64'(rd_mask),   4'b0010);
    check("t5 rd_pc",     64'(rd_pc),     32'h90);

    // Asynchronous reset with three records queued.
    fetch_once(32'h90);
    fetch_once(32'h90);
    check("t6 hits queued", 64'(hit_count), 3);
    #2 rstn = 1'b0;
    #1;
    check("t6 async rd_valid",  64'(rd_valid),  0);
    check("t6 async halt_req",  64'(halt_req),  0);
    check("t6 async mon_state", 64'(mon_state), 0);
    check("t6 async hit_count", 64'(hit_count), 0);
    model_reset();
    tick();
    rstn = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
